// File: rtl/vga_rect_writer_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_rect_writer_if
// Description : Command / pixel-write bundle between a rectangle client and
//               vga_rect_writer. The master issues rectangle commands and
//               observes status plus the framebuffer write port; the slave
//               (the writer) accepts commands and drives the write port.
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_rect_writer_if #(
    parameter int nX          = 10,
    parameter int nY          = 9,
    parameter int COLOR_DEPTH = 9
);
    logic                   start;
    logic [nX-1:0]          x0;
    logic [nY-1:0]          y0;
    logic [nX-1:0]          w;
    logic [nY-1:0]          h;
    logic [COLOR_DEPTH-1:0] color_in;
    logic                   mode;
    logic                   busy;
    logic                   done;
    logic [nX-1:0]          vga_x;
    logic [nY-1:0]          vga_y;
    logic [COLOR_DEPTH-1:0] vga_color;
    logic                   vga_write;

    modport master (
        output start, x0, y0, w, h, color_in, mode,
        input  busy, done, vga_x, vga_y, vga_color, vga_write
    );

    modport slave (
        input  start, x0, y0, w, h, color_in, mode,
        output busy, done, vga_x, vga_y, vga_color, vga_write
    );
endinterface
`default_nettype wire

// File: rtl/vga_rect_writer.sv
`default_nettype none
// ============================================================================
// Module      : vga_rect_writer
// Description : Rectangle pixel engine feeding the vga_adapter write port.
//               One command at a time (solid fill or 1-pixel outline), one
//               pixel slot per clock in raster order, clipped to XRES x YRES.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_rect_writer #(
    parameter int nX          = 10,
    parameter int nY          = 9,
    parameter int COLOR_DEPTH = 9,
    parameter int XRES        = 640,
    parameter int YRES        = 480
) (
    input  wire logic         clock,
    input  wire logic         reset,
    vga_rect_writer_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DRAW = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [nX:0]   c_XRES  = (nX+1)'(XRES);
    localparam logic [nY:0]   c_YRES  = (nY+1)'(YRES);
    localparam logic [nX-1:0] c_ONE_X = nX'(1);
    localparam logic [nY-1:0] c_ONE_Y = nY'(1);

    state_t                 r_state;
    state_t                 w_state_nxt;

    // Latched command
    logic [nX-1:0]          r_x0;
    logic [nY-1:0]          r_y0;
    logic [nX-1:0]          r_w;
    logic [nY-1:0]          r_h;
    logic [COLOR_DEPTH-1:0] r_color;
    logic                   r_mode;

    // Index of the pixel currently presented on the write port
    logic [nX-1:0]          r_cx;
    logic [nY-1:0]          r_cy;
    logic [nX-1:0]          w_cx_nxt;
    logic [nY-1:0]          w_cy_nxt;

    // Registered outputs
    logic                   r_busy;
    logic                   r_done;
    logic                   r_vga_write;
    logic [nX-1:0]          r_vga_x;
    logic [nY-1:0]          r_vga_y;
    logic [COLOR_DEPTH-1:0] r_vga_color;

    logic                   w_busy_nxt;
    logic                   w_done_nxt;
    logic                   w_emit;

    // Command source: live inputs on the accepting edge, latched copy after
    logic                   w_idle;
    logic [nX-1:0]          w_src_x0;
    logic [nY-1:0]          w_src_y0;
    logic [nX-1:0]          w_src_w;
    logic [nY-1:0]          w_src_h;
    logic [COLOR_DEPTH-1:0] w_src_color;
    logic                   w_src_mode;

    logic [nX:0]            w_px;
    logic [nY:0]            w_py;
    logic                   w_visible;
    logic                   w_selected;
    logic                   w_last_col;
    logic                   w_last_row;

    assign w_idle      = (r_state == S_IDLE);
    assign w_src_x0    = w_idle ? bus.x0       : r_x0;
    assign w_src_y0    = w_idle ? bus.y0       : r_y0;
    assign w_src_w     = w_idle ? bus.w        : r_w;
    assign w_src_h     = w_idle ? bus.h        : r_h;
    assign w_src_color = w_idle ? bus.color_in : r_color;
    assign w_src_mode  = w_idle ? bus.mode     : r_mode;

    assign w_last_col  = (r_cx == r_w - c_ONE_X);
    assign w_last_row  = (r_cy == r_h - c_ONE_Y);

    // One extra bit on the screen coordinate so an off-screen pixel never wraps on-screen
    assign w_px        = {1'b0, w_src_x0} + {1'b0, w_cx_nxt};
    assign w_py        = {1'b0, w_src_y0} + {1'b0, w_cy_nxt};
    assign w_visible   = (w_px < c_XRES) && (w_py < c_YRES);
    assign w_selected  = !w_src_mode
                       || (w_cx_nxt == '0) || (w_cx_nxt == w_src_w - c_ONE_X)
                       || (w_cy_nxt == '0) || (w_cy_nxt == w_src_h - c_ONE_Y);

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, counter advance and which pixel (if any) is presented next
    always_comb begin
        w_state_nxt = r_state;
        w_cx_nxt    = r_cx;
        w_cy_nxt    = r_cy;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        w_emit      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_cx_nxt   = '0;
                    w_cy_nxt   = '0;
                    w_busy_nxt = 1'b1;
                    if ((bus.w == '0) || (bus.h == '0)) begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = S_DRAW;
                        w_emit      = 1'b1;
                    end
                end
            end
            S_DRAW: begin
                w_busy_nxt = 1'b1;
                if (w_last_col && w_last_row) begin
                    w_state_nxt = S_DONE;
                    w_done_nxt  = 1'b1;
                end else if (w_last_col) begin
                    w_cx_nxt = '0;
                    w_cy_nxt = r_cy + c_ONE_Y;
                    w_emit   = 1'b1;
                end else begin
                    w_cx_nxt = r_cx + c_ONE_X;
                    w_emit   = 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Command capture on the accepting edge
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_x0    <= '0;
            r_y0    <= '0;
            r_w     <= '0;
            r_h     <= '0;
            r_color <= '0;
            r_mode  <= 1'b0;
        end else if (w_idle && bus.start) begin
            r_x0    <= bus.x0;
            r_y0    <= bus.y0;
            r_w     <= bus.w;
            r_h     <= bus.h;
            r_color <= bus.color_in;
            r_mode  <= bus.mode;
        end
    end

    // Pixel counters and registered write port / status outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cx        <= '0;
            r_cy        <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_vga_write <= 1'b0;
            r_vga_x     <= '0;
            r_vga_y     <= '0;
            r_vga_color <= '0;
        end else begin
            r_cx        <= w_cx_nxt;
            r_cy        <= w_cy_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_vga_write <= w_emit && w_visible && w_selected;
            if (w_emit) begin
                r_vga_x     <= w_px[nX-1:0];
                r_vga_y     <= w_py[nY-1:0];
                r_vga_color <= w_src_color;
            end
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.vga_write = r_vga_write;
    assign bus.vga_x     = r_vga_x;
    assign bus.vga_y     = r_vga_y;
    assign bus.vga_color = r_vga_color;

endmodule
`default_nettype wire

// File: tb/tb_vga_rect_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_rect_writer
// Description : Self-checking bench for vga_rect_writer. A reference model
//               expands each rectangle command into its expected per-cycle
//               write stream; directed and random commands are compared
//               cycle by cycle against the write port and status outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_rect_writer;

    localparam int nX   = 10;
    localparam int nY   = 9;
    localparam int CD   = 9;
    localparam int XRES = 640;
    localparam int YRES = 480;

    typedef struct {
        bit          wr;
        logic [9:0]  x;
        logic [8:0]  y;
        logic [8:0]  c;
    } pix_t;

    logic clk;
    logic rst;
    int   r_vectors;
    int   r_errors;

    vga_rect_writer_if #(.nX(nX), .nY(nY), .COLOR_DEPTH(CD)) bus ();

    vga_rect_writer #(
        .nX(nX), .nY(nY), .COLOR_DEPTH(CD), .XRES(XRES), .YRES(YRES)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        r_vectors++;
        if (got !== exp) begin
            r_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic noise_inputs(input bit with_start);
        bus.start    = with_start ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.x0       = 10'($urandom);
        bus.y0       = 9'($urandom);
        bus.w        = 10'($urandom_range(0, 7));
        bus.h        = 9'($urandom_range(0, 7));
        bus.color_in = 9'($urandom);
        bus.mode     = 1'($urandom_range(0, 1));
    endtask

    // Reference: every (cx,cy) cell of the rectangle in raster order, one per cycle
    task automatic run_cmd(input int x0, input int y0, input int w, input int h,
                           input int col, input bit m, input bit noisy);
        pix_t exp_q[$];
        pix_t p;
        for (int cy = 0; cy < h; cy++) begin
            for (int cx = 0; cx < w; cx++) begin
                int sx;
                int sy;
                bit border;
                sx     = x0 + cx;
                sy     = y0 + cy;
                border = (cx == 0) || (cx == w - 1) || (cy == 0) || (cy == h - 1);
                p.wr   = (sx < XRES) && (sy < YRES) && (!m || border);
                p.x    = 10'(sx);
                p.y    = 9'(sy);
                p.c    = 9'(col);
                exp_q.push_back(p);
            end
        end
        // issue command, sampled on the next rising edge
        bus.start    = 1'b1;
        bus.x0       = 10'(x0);
        bus.y0       = 9'(y0);
        bus.w        = 10'(w);
        bus.h        = 9'(h);
        bus.color_in = 9'(col);
        bus.mode     = m;
        @(negedge clk);
        if (noisy) noise_inputs(1'b1);
        else bus.start = 1'b0;
        foreach (exp_q[i]) begin
            chk("draw_busy", 32'(bus.busy), 32'd1);
            chk("draw_done", 32'(bus.done), 32'd0);
            chk("draw_wr",   32'(bus.vga_write), 32'(exp_q[i].wr));
            if (exp_q[i].wr)
                chk("draw_pix", {4'd0, bus.vga_x, bus.vga_y, bus.vga_color},
                    {4'd0, exp_q[i].x, exp_q[i].y, exp_q[i].c});
            if (noisy) noise_inputs(1'b1);
            @(negedge clk);
        end
        bus.start = 1'b0;
        chk("done_pulse", 32'(bus.done), 32'd1);
        chk("done_busy",  32'(bus.busy), 32'd1);
        chk("done_wr",    32'(bus.vga_write), 32'd0);
        @(negedge clk);
        chk("idle_busy",  32'(bus.busy), 32'd0);
        chk("idle_done",  32'(bus.done), 32'd0);
        chk("idle_wr",    32'(bus.vga_write), 32'd0);
    endtask

    initial begin
        r_vectors = 0;
        r_errors  = 0;
        rst       = 1'b1;
        noise_inputs(1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_wr",   32'(bus.vga_write), 32'd0);
        chk("rst_pix",  {4'd0, bus.vga_x, bus.vga_y, bus.vga_color}, 32'd0);

        // directed commands
        run_cmd(5,   3,   2, 2, 'h1C0, 1'b0, 1'b0);
        run_cmd(10,  10,  3, 3, 'h0AA, 1'b1, 1'b0);
        run_cmd(638, 479, 4, 2, 'h155, 1'b0, 1'b0);
        run_cmd(20,  20,  0, 5, 'h1FF, 1'b0, 1'b0);
        run_cmd(20,  20,  5, 0, 'h1FF, 1'b1, 1'b0);
        run_cmd(100, 50,  4, 3, 'h033, 1'b0, 1'b1);
        run_cmd(30,  40,  1, 4, 'h101, 1'b1, 1'b0);
        run_cmd(30,  40,  5, 1, 'h102, 1'b1, 1'b0);
        run_cmd(1020, 508, 6, 5, 'h0F0, 1'b0, 1'b0);

        // asynchronous reset in the middle of a 4x4 fill
        bus.start = 1'b1; bus.x0 = 10'd200; bus.y0 = 9'd100;
        bus.w = 10'd4; bus.h = 9'd4; bus.color_in = 9'h1E3; bus.mode = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_wr", 32'(bus.vga_write), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_wr",   32'(bus.vga_write), 32'd0);
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_wr",   32'(bus.vga_write), 32'd0);
            chk("post_rst_busy", 32'(bus.busy), 32'd0);
        end
        run_cmd(300, 200, 1, 1, 'h07E, 1'b0, 1'b0);

        // random commands, biased toward the screen edges
        for (int n = 0; n < 60; n++) begin
            int rx;
            int ry;
            rx = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 1023))
                                             : 630 + int'($urandom_range(0, 20));
            ry = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 511))
                                             : 470 + int'($urandom_range(0, 41));
            run_cmd(rx, ry, int'($urandom_range(0, 6)), int'($urandom_range(0, 5)),
                    int'($urandom_range(0, 511)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", r_vectors, r_errors);
        $finish;
    end

endmodule
`default_nettype wire
